cpu_vec_dma: RTL
================

Name: cpu_vec_dma

Overview:
Memory-side initiator that drives the single-port CPU RAM (write-enable, byte address, write data, combinational read data). On a start command it walks one or two source vectors and a destination vector element by element, performing copy, add, subtract or fill, and writes results back through the same RAM port. It sits between the CPU control unit and the RAM and owns the RAM port while busy.

Parameters:
ADDR_W, 8, RAM address width; addresses wrap modulo 2^ADDR_W.
DATA_W, 8, RAM word width; arithmetic is modulo 2^DATA_W.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  command strobe, sampled only in IDLE
op  input  2  00 COPY, 01 ADD, 10 SUB, 11 FILL
src_a  input  ADDR_W  vector A base; FILL value for op 11
src_b  input  ADDR_W  vector B base (ADD/SUB only)
dst  input  ADDR_W  destination base
len  input  8  element count, 0..255
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse at end of command
carry  output  1  sticky: any ADD carry-out or SUB borrow during the command
mem_enable  output  1  RAM write enable
adress  output  ADDR_W  RAM address
din  output  DATA_W  RAM write data
dout_ram  input  DATA_W  RAM read data, valid in the cycle its address is driven

Behaviour:
- Reset (async, immediate): state IDLE; busy, done, carry, mem_enable = 0; adress, din = 0; pointers and count = 0.
- IDLE: with start=1, latch op, src_a, src_b, dst, len and clear carry. If len=0, go to DONE. Otherwise COPY/ADD/SUB go to RD_A and FILL goes to WR. start is ignored in every other state.
- RD_A: adress=a_ptr, mem_enable=0. At the clock edge, op_a <= dout_ram. Next state is RD_B for ADD/SUB and WR for COPY.
- RD_B: adress=b_ptr, mem_enable=0. At the clock edge, op_b <= dout_ram. Next state is WR.
- WR: adress=d_ptr, mem_enable=1, din=result.
  - result: COPY = op_a; ADD = op_a+op_b; SUB = op_a-op_b; FILL = latched src_a[DATA_W-1:0].
  - At the clock edge: carry |= carry/borrow (ADD/SUB only); increment a_ptr, b_ptr and d_ptr (wrap 0xFF->0x00); decrement count.
  - Next state is DONE if count was 1. Otherwise RD_A, or WR for FILL.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE. carry holds its value until the next accepted start.
- Outputs are Moore, decoded from registered state and pointers only. dout_ram never feeds an output combinationally.
- Cycles per element: ADD/SUB 3, COPY 2, FILL 1. For a start sampled at edge 0, done is high in cycle k*len+1, where k is the cycles per element.
- Overlapping ranges: each element is read before it is written. This gives forward-copy semantics, and no overlap detection is performed.
- Reset mid-command: mem_enable drops immediately and no further writes occur. Writes already committed remain in RAM.
- mem_enable is 0 in IDLE, RD_A, RD_B and DONE.

Decomposition:
- Package cpu_vec_pkg holds:
  - op codes OP_COPY, OP_ADD, OP_SUB, OP_FILL;
  - the state enum IDLE/RD_A/RD_B/WR/DONE;
  - ADDR_W/DATA_W defaults.
- One sub-module, cpu_vec_alu: combinational, inputs op, op_a, op_b, fill value; outputs result[DATA_W-1:0] and cy.
- The FSM, pointers and counter live in cpu_vec_dma.

Test Plan:
- RAM 0x0a..0x0e = 2,3,4,5,6 and 0x80..0x84 = 1,2,3,4,5. ADD src_a=0x0a, src_b=0x80, dst=0x90, len=5 -> RAM 0x90..0x94 = 3,5,7,9,11; done high in cycle 16 only; carry=0; busy high cycles 1-16.
- SUB src_a=0x80, src_b=0x0a, dst=0xA0, len=5 -> 0xA0..0xA4 = 0xFF ×5; carry=1.
- COPY src_a=0xFE, dst=0x40, len=4 -> reads 0xFE, 0xFF, 0x00, 0x01 (wrap); 0x40..0x43 = 0,0,0,0; done in cycle 9. FILL src_a=0x5A, dst=0xFF, len=2 -> RAM 0xFF and 0x00 = 0x5A; done in cycle 3.
- len=0 with any op -> no mem_enable pulse; done in cycle 1; busy high cycle 1 only. A start pulse while busy -> ignored, and the original command completes unchanged.
- Reset asserted during WR of element 3 of the first ADD test -> mem_enable=0 immediately; 0x90..0x91 hold 3,5; 0x92..0x94 unchanged; all outputs 0. After release, a new ADD completes correctly.

Source files
------------

// File: rtl/cpu_vec_pkg.sv
// cpu_vec_pkg: op codes, FSM states and default widths shared by the vector DMA.
package cpu_vec_pkg;
   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DATA_W = 8;
   typedef enum logic [1:0] {OP_COPY, OP_ADD, OP_SUB, OP_FILL} op_e;
   typedef enum logic [2:0] {IDLE, RD_A, RD_B, WR, DONE} state_e;
endpackage

// File: rtl/cpu_vec_dma_if.sv
// cpu_vec_dma_if: single-port CPU RAM bus.
//   mem_enable: write enable; adress: byte address; din: write data;
//   dout_ram: combinational read data for the driven address.
//   master = initiator (DMA), slave = RAM.
interface cpu_vec_dma_if #(parameter int ADDR_W = 8, parameter int DATA_W = 8);
   logic              mem_enable;
   logic [ADDR_W-1:0] adress;
   logic [DATA_W-1:0] din;
   logic [DATA_W-1:0] dout_ram;
   modport master (output mem_enable, adress, din, input dout_ram);
   modport slave  (input mem_enable, adress, din, output dout_ram);
endinterface

// File: rtl/cpu_vec_alu.sv
// cpu_vec_alu: combinational element operation.
//   op: operation; op_a/op_b: operands; fill: FILL value;
//   result: element result; cy: ADD carry-out or SUB borrow.
module cpu_vec_alu
   import cpu_vec_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  op_e               op,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   input  logic [DATA_W-1:0] fill,
   output logic [DATA_W-1:0] result,
   output logic              cy
);
   logic [DATA_W:0] sum, dif;
   assign sum = {1'b0, op_a} + {1'b0, op_b};
   // Top bit of the widened difference is the borrow out.
   assign dif = {1'b0, op_a} - {1'b0, op_b};
   always_comb begin
      result = op == OP_ADD ? sum[DATA_W-1:0] : op == OP_SUB ? dif[DATA_W-1:0] : op == OP_FILL ? fill : op_a;
      cy     = op == OP_ADD ? sum[DATA_W] : op == OP_SUB ? dif[DATA_W] : 1'b0;
   end
endmodule

// File: rtl/cpu_vec_dma.sv
// cpu_vec_dma: vector copy/add/sub/fill engine owning the CPU RAM port while busy.
//   start/op/src_a/src_b/dst/len: command, accepted only in IDLE;
//   busy: not IDLE; done: one-cycle end pulse; carry: sticky carry/borrow;
//   ram: RAM bus (master side). All outputs decode registered state only.
module cpu_vec_dma
   import cpu_vec_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [ADDR_W-1:0] src_a,
   input  logic [ADDR_W-1:0] src_b,
   input  logic [ADDR_W-1:0] dst,
   input  logic [7:0]        len,
   output logic              busy,
   output logic              done,
   output logic              carry,
   cpu_vec_dma_if.master     ram
);
   state_e            state_q, state_d;
   op_e               op_q, op_d;
   logic [ADDR_W-1:0] a_ptr_q, a_ptr_d, b_ptr_q, b_ptr_d, d_ptr_q, d_ptr_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] fill_q, fill_d, op_a_q, op_a_d, op_b_q, op_b_d;
   logic              carry_q, carry_d;
   logic [DATA_W-1:0] result;
   logic              cy;

   cpu_vec_alu #(.DATA_W(DATA_W)) u_alu (
      .op(op_q), .op_a(op_a_q), .op_b(op_b_q), .fill(fill_q), .result(result), .cy(cy)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= OP_COPY;
         a_ptr_q <= '0;
         b_ptr_q <= '0;
         d_ptr_q <= '0;
         cnt_q   <= '0;
         fill_q  <= '0;
         op_a_q  <= '0;
         op_b_q  <= '0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_ptr_q <= a_ptr_d;
         b_ptr_q <= b_ptr_d;
         d_ptr_q <= d_ptr_d;
         cnt_q   <= cnt_d;
         fill_q  <= fill_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         carry_q <= carry_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_ptr_d = a_ptr_q;
      b_ptr_d = b_ptr_q;
      d_ptr_d = d_ptr_q;
      cnt_d   = cnt_q;
      fill_d  = fill_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      carry_d = carry_q;
      case (state_q)
         IDLE: if (start) begin
            op_d    = op_e'(op);
            a_ptr_d = src_a;
            b_ptr_d = src_b;
            d_ptr_d = dst;
            cnt_d   = len;
            fill_d  = DATA_W'(src_a);
            carry_d = 1'b0;
            state_d = len == 8'd0 ? DONE : op_e'(op) == OP_FILL ? WR : RD_A;
         end
         RD_A: begin
            op_a_d  = ram.dout_ram;
            state_d = (op_q == OP_ADD || op_q == OP_SUB) ? RD_B : WR;
         end
         RD_B: begin
            op_b_d  = ram.dout_ram;
            state_d = WR;
         end
         WR: begin
            carry_d = carry_q | cy;
            a_ptr_d = a_ptr_q + 1'b1;
            b_ptr_d = b_ptr_q + 1'b1;
            d_ptr_d = d_ptr_q + 1'b1;
            cnt_d   = cnt_q - 8'd1;
            state_d = cnt_q == 8'd1 ? DONE : op_q == OP_FILL ? WR : RD_A;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy           = state_q != IDLE;
   assign done           = state_q == DONE;
   assign carry          = carry_q;
   assign ram.mem_enable = state_q == WR;
   assign ram.adress     = state_q == RD_A ? a_ptr_q : state_q == RD_B ? b_ptr_q : state_q == WR ? d_ptr_q : '0;
   assign ram.din        = state_q == WR ? result : '0;
endmodule
